timing_adapter_fifo_param: RTL

//  Parametrised show-ahead Avalon-ST timing-adapter FIFO between the TSE MAC and the application.

---
 rtl/timing_adapter_fifo_param_if.sv | 17 +
 rtl/timing_adapter_fifo_param.sv | 129 ++++++++++++
 2 files changed

// File: rtl/timing_adapter_fifo_param_if.sv
// rtl/timing_adapter_fifo_param_if.sv - valid/ready/data stream bundle for the timing-adapter FIFO
//
// Purpose: one Avalon-ST style stream leg (word plus handshake).
// Signals:
//   valid  word on data is valid (master -> slave)
//   ready  slave accepts the word this cycle (slave -> master)
//   data   DATA_WIDTH-bit word, opaque payload (master -> slave)
interface timing_adapter_fifo_param_if #(
    parameter int DATA_WIDTH = 11
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/timing_adapter_fifo_param.sv
// rtl/timing_adapter_fifo_param.sv - parametrised show-ahead timing-adapter FIFO
//
// Purpose: decouples the MAC-side stream from the application-side stream.
//   Show-ahead: the oldest stored word sits registered on out_st.data.
//   Provides fill level, almost-full/almost-empty flags, a synchronous flush and
//   a saturating count of words dropped while in_st.ready was low.
// Ports:
//   clk           clock
//   reset         asynchronous, active-high reset
//   flush         synchronous clear of all contents
//   in_st         upstream stream (slave): valid/data in, ready out
//   out_st        downstream stream (master): valid/data out, ready in
//   fill_level    words held, 0..DEPTH, including the word on out_st.data
//   almost_full   fill_level >= ALMOST_FULL_TH
//   almost_empty  fill_level <= ALMOST_EMPTY_TH
//   overflow_cnt  saturating count of dropped words
module timing_adapter_fifo_param #(
    parameter int DATA_WIDTH      = 11,
    parameter int DEPTH           = 64,
    parameter int ADDR_WIDTH      = 6,
    parameter int ALMOST_FULL_TH  = 56,
    parameter int ALMOST_EMPTY_TH = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    timing_adapter_fifo_param_if.slave  in_st,
    timing_adapter_fifo_param_if.master out_st,
    output logic [ADDR_WIDTH:0]       fill_level,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [CNT_WIDTH-1:0]      overflow_cnt
);

    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_LEVEL   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0]   AE_LEVEL   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
    localparam logic [ADDR_WIDTH:0]   FILL_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   FILL_TWO   = 2;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr_inc;
    logic [ADDR_WIDTH:0]   fill_next;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  wr_en;
    logic                  rd_en;

    // in_ready depends only on the registered fill level, never on out_st.ready.
    assign in_st.ready = (fill_level != FULL_LEVEL);
    assign out_st.valid = out_valid_q;
    assign out_st.data  = out_data_q;

    assign wr_en      = in_st.valid && in_st.ready;
    assign rd_en      = out_valid_q && out_st.ready;
    assign rd_ptr_inc = rd_ptr + PTR_ONE;

    always_comb begin
        fill_next = fill_level;
        if (flush) begin
            fill_next = '0;
        end else if (wr_en && !rd_en) begin
            fill_next = fill_level + FILL_ONE;
        end else if (!wr_en && rd_en) begin
            fill_next = fill_level - FILL_ONE;
        end
    end

    // Storage has no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= in_st.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow_cnt <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            fill_level   <= fill_next;
            almost_full  <= (fill_next >= AF_LEVEL);
            almost_empty <= (fill_next <= AE_LEVEL);

            // Dropped words are counted even on a flush edge; flush never clears the count.
            if (in_st.valid && !in_st.ready && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + CNT_ONE;
            end

            if (flush) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                out_valid_q <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr_inc;
                    if (fill_level >= FILL_TWO) begin
                        // Successor was written on an earlier edge, so memory holds it.
                        out_data_q <= mem[rd_ptr_inc];
                    end else if (wr_en) begin
                        // Only word is leaving while its successor arrives: bypass memory.
                        out_data_q <= in_st.data;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end else if (!out_valid_q && (fill_level != '0)) begin
                    // First word after empty becomes visible one edge after its write.
                    out_data_q  <= mem[rd_ptr];
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule
